// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the dual-port RAM arbiter slice.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default RAM address and data widths
//   state_t                         : arbiter FSM state encoding
//   port_t                          : identifies a requesting port (A or B)
package ram_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Two-way round-robin selector.
//   req_a, req_b : request inputs of port A and port B
//   last_grant   : port that owned the most recent transaction
//   grant        : selected port; only meaningful while a request is present
module rr_pick2
  import ram_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_grant,
  output port_t grant
);

  // A tie goes to whichever port did not win last time; a lone request wins
  // straight away.
  always_comb begin
    grant = PORT_A;
    if (req_a && req_b) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one asynchronous-style RAM between two request/acknowledge ports.
// Each transaction walks IDLE -> SETUP -> STROBE -> HOLD -> DONE, producing a
// single RamClock pulse in STROBE and a one-cycle Ack in DONE.
//   Clock, nReset          : system clock, synchronous active-low reset
//   AReq/AWrite/AAddr/AWData, AAck/ARData : port A request and response
//   BReq/BWrite/BAddr/BWData, BAck/BRData : port B request and response
//   RamClock/RamAddress/RamReadWrite      : RAM strobe, address, direction
//   RamData                               : bidirectional RAM data bus
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              AReq,
  input  logic              AWrite,
  input  logic [ADDR_W-1:0] AAddr,
  input  logic [DATA_W-1:0] AWData,
  output logic              AAck,
  output logic [DATA_W-1:0] ARData,
  input  logic              BReq,
  input  logic              BWrite,
  input  logic [ADDR_W-1:0] BAddr,
  input  logic [DATA_W-1:0] BWData,
  output logic              BAck,
  output logic [DATA_W-1:0] BRData,
  output logic              RamClock,
  output logic [ADDR_W-1:0] RamAddress,
  output logic              RamReadWrite,
  inout  wire  [DATA_W-1:0] RamData
);

  state_t            state_q, state_d;
  port_t             grant_q, grant_d;
  port_t             pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              bus_drive;

  // grant_q doubles as the round-robin history: it names the owner of the
  // current transaction and, once idle, the port that was served last.
  rr_pick2 u_pick (
    .req_a      (AReq),
    .req_b      (BReq),
    .last_grant (grant_q),
    .grant      (pick)
  );

  // Next-state logic. The winner's command is captured on leaving IDLE so the
  // ports may change or drop their inputs without disturbing the RAM cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        rw_d = 1'b0;
        if (AReq || BReq) begin
          state_d = SETUP;
          grant_d = pick;
          if (pick == PORT_A) begin
            rw_d    = AWrite;
            addr_d  = AAddr;
            wdata_d = AWData;
          end else begin
            rw_d    = BWrite;
            addr_d  = BAddr;
            wdata_d = BWData;
          end
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        state_d = DONE;
        // Read data is taken from the bus on the way out of HOLD, while the
        // RAM is still driving it.
        if (!rw_q) begin
          if (grant_q == PORT_A) begin
            a_rdata_d = RamData;
          end else begin
            b_rdata_d = RamData;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        rw_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q   <= IDLE;
      grant_q   <= PORT_B;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // The bus is only ours for the three RAM-facing phases of a write.
  assign bus_drive    = rw_q && (state_q == SETUP || state_q == STROBE || state_q == HOLD);
  assign RamData      = bus_drive ? wdata_q : {DATA_W{1'bz}};
  assign RamClock     = (state_q == STROBE);
  assign RamAddress   = addr_q;
  assign RamReadWrite = rw_q;
  assign AAck         = (state_q == DONE) && (grant_q == PORT_A);
  assign BAck         = (state_q == DONE) && (grant_q == PORT_B);
  assign ARData       = a_rdata_q;
  assign BRData       = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a small behavioural RAM on the shared
// bus. The bus is pulled up, so an undriven bus reads as all ones.
module tb_ram_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              Clock = 1'b0;
  logic              nReset;
  logic              AReq, AWrite, BReq, BWrite;
  logic [ADDR_W-1:0] AAddr, BAddr;
  logic [DATA_W-1:0] AWData, BWData;
  logic              AAck, BAck;
  logic [DATA_W-1:0] ARData, BRData;
  logic              RamClock, RamReadWrite;
  logic [ADDR_W-1:0] RamAddress;
  tri1  [DATA_W-1:0] RamData;

  logic [DATA_W-1:0] ramMem [0:255];
  logic              ramDrive = 1'b0;
  logic [DATA_W-1:0] ramOut = '0;
  int                ramAge = 0;

  int testsRun    = 0;
  int testsFailed = 0;

  int                lat, pulses;
  logic              gotA, gotB, sRw, prevA;
  logic [ADDR_W-1:0] sAddr;
  logic [DATA_W-1:0] sData, firstData, aData, bData;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .AReq         (AReq),
    .AWrite       (AWrite),
    .AAddr        (AAddr),
    .AWData       (AWData),
    .AAck         (AAck),
    .ARData       (ARData),
    .BReq         (BReq),
    .BWrite       (BWrite),
    .BAddr        (BAddr),
    .BWData       (BWData),
    .BAck         (BAck),
    .BRData       (BRData),
    .RamClock     (RamClock),
    .RamAddress   (RamAddress),
    .RamReadWrite (RamReadWrite),
    .RamData      (RamData)
  );

  always #5 Clock = ~Clock;

  // Behavioural RAM: acts while the strobe is high; read data is driven from
  // the strobe cycle through the following hold cycle, then released.
  assign RamData = ramDrive ? ramOut : {DATA_W{1'bz}};

  always @(negedge Clock) begin
    if (ramDrive) begin
      ramAge <= ramAge + 1;
      if (ramAge == 1) ramDrive <= 1'b0;
    end
    if (RamClock) begin
      if (RamReadWrite) begin
        ramMem[RamAddress] <= RamData;
      end else begin
        ramDrive <= 1'b1;
        ramOut   <= ramMem[RamAddress];
        ramAge   <= 0;
      end
    end
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents both ports' request inputs at once.
  task automatic applyStimulus(input logic aR, input logic aW, input logic [7:0] aA,
                               input logic [7:0] aD, input logic bR, input logic bW,
                               input logic [7:0] bA, input logic [7:0] bD);
    AReq = aR; AWrite = aW; AAddr = aA; AWData = aD;
    BReq = bR; BWrite = bW; BAddr = bA; BWData = bD;
  endtask

  // Samples on falling edges until an Ack appears or the budget runs out.
  // lat is the number of samples taken, 0 if no Ack was seen.
  task automatic waitAck(input int budget, output int latOut, output logic aOut,
                         output logic bOut, output int pulseOut,
                         output logic [7:0] addrOut, output logic rwOut,
                         output logic [7:0] dataOut, output logic [7:0] firstOut,
                         output logic [7:0] aRd, output logic [7:0] bRd);
    bit done = 0;
    latOut = 0; aOut = 0; bOut = 0; pulseOut = 0;
    addrOut = '0; rwOut = 0; dataOut = '0; firstOut = '0; aRd = '0; bRd = '0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(negedge Clock);
      if (i == 1) firstOut = RamData;
      if (RamClock) begin
        pulseOut++;
        addrOut = RamAddress;
        rwOut   = RamReadWrite;
        dataOut = RamData;
      end
      if (AAck || BAck) begin
        latOut = i; aOut = AAck; bOut = BAck; aRd = ARData; bRd = BRData;
        done = 1;
      end
    end
  endtask

  initial begin
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("rstRamClock", RamClock, 0);
    checkOutput("rstRamRw", RamReadWrite, 0);
    checkOutput("rstRamAddr", RamAddress, 0);
    checkOutput("rstAcks", {AAck, BAck}, 0);
    checkOutput("rstRData", {ARData, BRData}, 0);
    checkOutput("rstBusZ", RamData, 8'hFF);
    nReset = 1'b1;
    @(negedge Clock);

    // Port A write addr 1 data 5
    applyStimulus(1, 1, 8'd1, 8'd5, 0, 0, 8'h00, 8'h00);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("wrA_lat", lat, 4);
    checkOutput("wrA_acks", {gotA, gotB}, 2'b10);
    checkOutput("wrA_pulses", pulses, 1);
    checkOutput("wrA_addr", sAddr, 1);
    checkOutput("wrA_rw", sRw, 1);
    checkOutput("wrA_data", sData, 5);
    checkOutput("wrA_setupData", firstData, 5);
    checkOutput("wrA_mem", ramMem[1], 5);
    @(negedge Clock);
    checkOutput("idleRw", RamReadWrite, 0);
    checkOutput("idleBusZ", RamData, 8'hFF);

    // Port B write addr 2 data 1
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'd2, 8'd1);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("wrB_lat", lat, 4);
    checkOutput("wrB_acks", {gotA, gotB}, 2'b01);
    checkOutput("wrB_data", sData, 1);
    checkOutput("wrB_mem", ramMem[2], 1);
    checkOutput("wrB_rdataKept", bData, 0);
    @(negedge Clock);

    // Port A read addr 1; the bus must stay undriven by the arbiter
    applyStimulus(1, 0, 8'd1, 8'h3C, 0, 0, 8'h00, 8'h00);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("rdA_lat", lat, 4);
    checkOutput("rdA_acks", {gotA, gotB}, 2'b10);
    checkOutput("rdA_rw", sRw, 0);
    checkOutput("rdA_setupBusZ", firstData, 8'hFF);
    checkOutput("rdA_data", aData, 5);
    checkOutput("rdA_bUnchanged", bData, 0);
    @(negedge Clock);
    checkOutput("rdA_idleBusZ", RamData, 8'hFF);

    // Reset, then simultaneous reads of addr 2: A first, B five cycles later
    nReset = 1'b0;
    @(negedge Clock);
    checkOutput("rst2_ARData", ARData, 0);
    nReset = 1'b1;
    applyStimulus(1, 0, 8'd2, 8'h3C, 1, 0, 8'd2, 8'h3C);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    AReq = 1'b0;
    checkOutput("tie_first", {gotA, gotB}, 2'b10);
    checkOutput("tie_firstLat", lat, 4);
    checkOutput("tie_ARData", aData, 1);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    BReq = 1'b0;
    checkOutput("tie_second", {gotA, gotB}, 2'b01);
    checkOutput("tie_gap", lat, 5);
    checkOutput("tie_BRData", bData, 1);
    @(negedge Clock);

    // Both requests held for four transactions: strict alternation from A
    applyStimulus(1, 0, 8'd1, 8'h3C, 1, 0, 8'd2, 8'h3C);
    prevA = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
      checkOutput($sformatf("rr_grant%0d", k), {gotA, gotB}, (k % 2 == 0) ? 2'b10 : 2'b01);
      checkOutput($sformatf("rr_lat%0d", k), lat, (k == 0) ? 4 : 5);
      if (k > 0) checkOutput($sformatf("rr_alt%0d", k), gotA, !prevA);
      prevA = gotA;
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge Clock);

    // Reset asserted while the strobe is high aborts the write
    applyStimulus(1, 1, 8'd3, 8'h77, 0, 0, 8'h00, 8'h00);
    repeat (2) @(negedge Clock);
    checkOutput("abort_strobe", RamClock, 1);
    nReset = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge Clock);
    checkOutput("abort_ramClock", RamClock, 0);
    checkOutput("abort_acks", {AAck, BAck}, 0);
    checkOutput("abort_busZ", RamData, 8'hFF);
    checkOutput("abort_rw", RamReadWrite, 0);
    nReset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checkOutput($sformatf("abort_quiet%0d", k), {AAck, BAck, RamClock}, 0);
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'd1, 8'h3C);
    waitAck(10, lat, gotA, gotB, pulses, sAddr, sRw, sData, firstData, aData, bData);
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("postAbort_lat", lat, 4);
    checkOutput("postAbort_acks", {gotA, gotB}, 2'b01);
    checkOutput("postAbort_BRData", bData, 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 Clock  input  1  system clock; all state changes on rising edge.
REQ-004 nReset  input  1  synchronous, active-low reset, sampled on Clock rising edge.
REQ-005 AReq  input  1  port A request; held high until AAck.
REQ-006 AWrite  input  1  port A direction (1=write, 0=read).
REQ-007 AAddr  input  ADDR_W  port A address.
REQ-008 AWData  input  DATA_W  port A write data.
REQ-009 AAck  output  1  port A completion pulse, one cycle.
REQ-010 ARData  output  DATA_W  port A read data, valid while AAck=1.
REQ-011 BReq, BWrite, BAddr, BWData, BAck, BRData: same directions, widths and meaning as the port A signals, for port B.
REQ-012 RamClock  output  1  strobe to the RAM; RAM acts on its rising edge.
REQ-013 RamAddress  output  ADDR_W  RAM address.
REQ-014 RamReadWrite  output  1  RAM direction (1=write, 0=read).
REQ-015 RamData  inout  DATA_W  shared RAM data bus.

Function
REQ-016 The FSM SHALL use states IDLE, SETUP, STROBE, HOLD, DONE; from SETUP onward each state lasts exactly one cycle.
REQ-017 In IDLE with any request high, the block SHALL latch the winner's Write/Addr/WData into RamReadWrite/RamAddress/write register and go to SETUP; with no request it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: on simultaneous AReq and BReq, grant the port not granted last; a single request is granted immediately.
REQ-019 SETUP: RamClock=0, address/direction/write data stable; STROBE: RamClock=1; HOLD: RamClock=0; then DONE; then IDLE.
REQ-020 RamData SHALL be driven with the latched write data only while RamReadWrite=1 in SETUP, STROBE or HOLD; otherwise it SHALL be high-impedance.
REQ-021 For reads, RamData SHALL be registered at the HOLD->DONE edge into the granted port's RData register.
REQ-022 In DONE, only the granted port's Ack SHALL be 1 for exactly one cycle; latency from the request-sampling edge to Ack high is 4 cycles.
REQ-023 Write transactions SHALL leave the granted port's RData unchanged.
REQ-024 Deassertion of Req mid-transaction SHALL NOT abort it; Ack is still pulsed.
REQ-025 Requests present during DONE SHALL be evaluated in the following IDLE cycle (minimum 5 cycles per transaction).
REQ-026 RamAddress and RamReadWrite SHALL hold their values through DONE; RamReadWrite SHALL return to 0 in IDLE.

Reset
REQ-027 On nReset=0: state IDLE, RamClock=0, RamReadWrite=0, RamAddress=0, RamData high-Z, AAck=BAck=0, ARData=BRData=0, last-grant=B (port A wins first tie).
REQ-028 Reset mid-transaction SHALL abort it: no Ack is issued, and RamClock SHALL be 0 from the cycle after the reset edge.

Structure
REQ-029 Shared package ram_pkg SHALL hold the ADDR_W/DATA_W defaults and the FSM state encoding.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick2 (inputs: two requests and last-grant; output: grant index).

Verification
REQ-031 Port A write addr 1 data 5 -> one RamClock pulse with RamAddress=1, RamReadWrite=1, RamData=5; AAck 4 cycles after the request-sampling edge.
REQ-032 Port B write addr 2 data 1, then port A read addr 1 -> ARData=5 with AAck; BRData unchanged.
REQ-033 AReq and BReq high together from reset, both reading addr 2 -> A served first, B next; both RData=1; Acks 5 cycles apart.
REQ-034 Both requests held high continuously for 4 transactions -> grant order A,B,A,B, never two consecutive grants to one port.
REQ-035 nReset low during STROBE -> RamClock 0 the next cycle, no Ack, RamData high-Z, FSM in IDLE.
REQ-036 Read transaction -> RamData never driven by the block (high-Z) throughout.
